aes_stream_ctrl: RTL
====================

Name: aes_stream_ctrl

Overview:
- Streaming front/back end for the iterative AES round core (`aes_top`). Sits directly around it: upstream it accepts 128-bit blocks plus key and direction over valid/ready, then drives the core's `text_in`, `key`, `encrypt` and `reset`.
- It counts the core's round latency, captures `text_out` at the right cycle, and buffers results in a small output FIFO with valid/ready.
- Converts the free-running, handshake-less core into a back-pressure-safe stream stage.

Parameters:
- DATA_W, 128, block width; must equal core `DATA_SIZE`.
- KEY_W, 128, key width; must equal core `KEY_SIZE`.
- CORE_LATENCY, 11, cycles from the core-reset cycle to the first cycle `core_text_out` is valid (`NO_OF_ROUNDS` + 1).
- OUT_DEPTH, 2, output FIFO entries, ≥1.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  upstream block valid.
- in_ready  out  1  stage can accept a block.
- in_text  in  DATA_W  plaintext or ciphertext.
- in_key  in  KEY_W  cipher key for this block.
- in_encrypt  in  1  1 = encrypt, 0 = decrypt.
- core_reset  out  1  active-high, synchronous load pulse to the core.
- core_text_in  out  DATA_W  held block to the core.
- core_key  out  KEY_W  held key to the core.
- core_encrypt  out  1  held direction to the core.
- core_text_out  in  DATA_W  core result.
- out_valid  out  1  result available.
- out_ready  in  1  downstream accepts.
- out_text  out  DATA_W  result (FIFO head).
- out_encrypt  out  1  direction tag of the head result.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - state = IDLE; all holding regs = 0; FIFO empty.
  - out_valid = 0, in_ready = 0 during reset.
  - core_reset = 1 during reset (holds the core idle).
- States: IDLE, LOAD, RUN.
- IDLE:
  - in_ready = 1 iff FIFO count + inflight < OUT_DEPTH (credit reserved per block). inflight is 0 in IDLE.
  - On in_valid & in_ready: latch text/key/encrypt into holding regs and go to LOAD.
- LOAD (1 cycle):
  - core_reset = 1; core inputs driven from the holding regs.
  - round counter rc cleared; go to RUN.
- RUN:
  - core_reset = 0; rc increments each cycle.
  - When rc == CORE_LATENCY-1: push {core_encrypt, core_text_out} into the FIFO and go to IDLE.
- Holding regs are stable from LOAD through the push cycle; core_encrypt never changes mid-block.
- Per-block latency, accept to out_valid: CORE_LATENCY+2 cycles with the FIFO empty.
- Throughput: one block per CORE_LATENCY+2 cycles.
- in_ready = 0 in LOAD and RUN.
- FIFO (first-word fall-through):
  - out_valid = !empty; out_text/out_encrypt = head.
  - Pop on out_valid & out_ready.
  - Simultaneous push and pop at count = OUT_DEPTH cannot occur, because credits forbid it. Push and pop in the same cycle at any other count leaves the count unchanged.
- Credits: a block is accepted only if a FIFO slot is guaranteed, so a push never overflows and never stalls the core.
- Pointers are clog2(OUT_DEPTH) bits and wrap modulo OUT_DEPTH; the count is clog2(OUT_DEPTH+1) bits.
- out_text is stable while out_valid & !out_ready.
- Reset mid-RUN: the block is discarded with no push, the FIFO is flushed, and the core is held in reset.
- A core_reset pulse is produced only in LOAD, plus the reset-held case.

Optional Feature:
- Macro AES_STREAM_BLOCK_CNT_EN.
- When defined:
  - Adds output port blk_cnt [31:0], reset 0, incremented on each FIFO push and wrapping at 2^32.
  - Adds input blk_cnt_clr; when high it synchronously zeroes blk_cnt, and clear wins over a simultaneous increment.
- When undefined: the ports are absent and no counter logic is generated.

Decomposition:
- Shared package/include `aes_defs` holds:
  - `DATA_SIZE`, `KEY_SIZE`, `NO_OF_ROUNDS`;
  - the state encodings (IDLE=2'd0, LOAD=2'd1, RUN=2'd2);
  - CORE_LATENCY default derived from `NO_OF_ROUNDS`.
- One sub-module: aes_out_fifo, a parameterised FWFT FIFO of width DATA_W+1 and depth OUT_DEPTH with count output.

Test Plan:
- Bench core stub: captures text_in^key on core_reset and presents it on core_text_out exactly CORE_LATENCY cycles later.
- Single block: in_text=0x00112233445566778899aabbccddeeff, in_key=0x000102030405060708090a0b0c0d0e0f, encrypt=1, out_ready=1 → out_valid on cycle 13 after accept; out_text=0x00102030405060708090a0b0c0d0e0f0; out_encrypt=1.
- Back-pressure: out_ready=0, push 3 blocks with OUT_DEPTH=2 → in_ready drops after the 2nd accept; the 3rd is accepted only after the first pop. Order is preserved and out_text is stable while stalled.
- Direction tag: alternate encrypt=1/0 on 4 blocks → core_encrypt is constant within each block; out_encrypt sequence is 1,0,1,0.
- Reset mid-RUN: assert reset at rc=5 → out_valid=0, core_reset=1, FIFO empty. After release, a new block completes normally with no stale output.
- AES_STREAM_BLOCK_CNT_EN: 5 blocks → blk_cnt=5. Assert blk_cnt_clr in the same cycle as the 6th push → blk_cnt=0.

Source files
------------

// File: rtl/aes_defs.sv
// Shared constants and state encoding for the AES round core and its stream wrapper.
package aes_defs;

  localparam int DATA_SIZE        = 128;
  localparam int KEY_SIZE         = 128;
  localparam int NO_OF_ROUNDS     = 10;
  localparam int CORE_LATENCY_DEF = NO_OF_ROUNDS + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_e;

endpackage

// File: rtl/aes_out_fifo.sv
// First-word-fall-through result FIFO with occupancy count; head is held steady until popped.
module aes_out_fifo #(
  parameter  int WIDTH = 129,
  parameter  int DEPTH = 2,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_dat_i,
  input  logic             pop_i,
  output logic             vld_o,
  output logic [WIDTH-1:0] dat_o,
  output logic [CNT_W-1:0] cnt_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             push_ok, pop_ok;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign push_ok = push_i && (cnt_q != CNT_W'(DEPTH));
  assign pop_ok  = pop_i && (cnt_q != '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_ok) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (pop_ok)  rd_ptr_d = ptr_inc(rd_ptr_q);
    if (push_ok && !pop_ok)      cnt_d = cnt_q + 1'b1;
    else if (pop_ok && !push_ok) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset: nothing is visible until the count says so.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_dat_i;
  end

  assign vld_o = (cnt_q != '0);
  assign dat_o = mem_q[rd_ptr_q];
  assign cnt_o = cnt_q;

endmodule

// File: rtl/aes_stream_ctrl.sv
// Valid/ready stream wrapper around the free-running AES round core; one block in flight at a time.
// Optional AES_STREAM_BLOCK_CNT_EN adds a pushed-block counter (blk_cnt) with synchronous clear.
module aes_stream_ctrl
  import aes_defs::*;
#(
  parameter int DATA_W       = DATA_SIZE,
  parameter int KEY_W        = KEY_SIZE,
  parameter int CORE_LATENCY = CORE_LATENCY_DEF,
  parameter int OUT_DEPTH    = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_text,
  input  logic [KEY_W-1:0]  in_key,
  input  logic              in_encrypt,
  output logic              core_reset,
  output logic [DATA_W-1:0] core_text_in,
  output logic [KEY_W-1:0]  core_key,
  output logic              core_encrypt,
  input  logic [DATA_W-1:0] core_text_out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_text,
  output logic              out_encrypt
`ifdef AES_STREAM_BLOCK_CNT_EN
  ,
  input  logic              blk_cnt_clr,
  output logic [31:0]       blk_cnt
`endif
);

  localparam int RC_W  = $clog2(CORE_LATENCY + 1);
  localparam int CNT_W = $clog2(OUT_DEPTH + 1);

  state_e            state_q, state_d;
  logic [RC_W-1:0]   rc_q, rc_d;
  logic [DATA_W-1:0] text_q;
  logic [KEY_W-1:0]  key_q;
  logic              enc_q;
  logic [CNT_W-1:0]  fifo_cnt;
  logic [DATA_W:0]   fifo_head;
  logic              slot_free, accept, push, pop;

  // Only one block is ever in flight, so a free FIFO slot at accept time is its credit.
  assign slot_free = int'(fifo_cnt) < OUT_DEPTH;
  assign in_ready  = reset && (state_q == IDLE) && slot_free;
  assign accept    = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    rc_d    = rc_q;
    push    = 1'b0;
    case (state_q)
      IDLE: if (accept) state_d = LOAD;
      LOAD: begin
        rc_d    = '0;
        state_d = RUN;
      end
      RUN: begin
        rc_d = rc_q + 1'b1;
        if (rc_q == RC_W'(CORE_LATENCY - 1)) begin
          push    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      rc_q    <= '0;
      text_q  <= '0;
      key_q   <= '0;
      enc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rc_q    <= rc_d;
      if (accept) begin
        text_q <= in_text;
        key_q  <= in_key;
        enc_q  <= in_encrypt;
      end
    end
  end

  assign core_reset   = !reset || (state_q == LOAD);
  assign core_text_in = text_q;
  assign core_key     = key_q;
  assign core_encrypt = enc_q;

  assign pop = out_valid && out_ready;

  aes_out_fifo #(
    .WIDTH (DATA_W + 1),
    .DEPTH (OUT_DEPTH)
  ) u_out_fifo (
    .clk_i      (clk),
    .rst_ni     (reset),
    .push_i     (push),
    .push_dat_i ({enc_q, core_text_out}),
    .pop_i      (pop),
    .vld_o      (out_valid),
    .dat_o      (fifo_head),
    .cnt_o      (fifo_cnt)
  );

  assign out_encrypt = fifo_head[DATA_W];
  assign out_text    = fifo_head[DATA_W-1:0];

`ifdef AES_STREAM_BLOCK_CNT_EN
  logic [31:0] blk_cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)          blk_cnt_q <= '0;
    else if (blk_cnt_clr) blk_cnt_q <= '0;
    else if (push)        blk_cnt_q <= blk_cnt_q + 32'd1;
  end

  assign blk_cnt = blk_cnt_q;
`endif

endmodule
